time_entry_register: RTL
========================

Name: time_entry_register

Overview:
Keypad entry stage for the Timer. It sits directly upstream of the decrementing BCD digit counters and converts one-hot keypad presses into a 3-digit M:SS entry buffer that shifts left on each press. On a start request it validates the entry and drives the counters' parallel data and active-low synchronous load for exactly one cycle. It also exposes the buffer so the display can show the entry while it is typed.

Parameters:
SEC_TENS_MAX, 5, largest legal seconds-tens digit; larger entries are rejected at start.
KEYS, 10, keypad width; bit i is digit i; fixed at 10.

Ports:
clock  in  1  single clock; all state updates on posedge
clear  in  1  synchronous reset, active-high; highest priority
keypad  in  KEYS  one-hot key lines, level, held while pressed
enable  in  1  high when the timer is stopped and entry is allowed
start  in  1  start request, sampled each cycle
cancel  in  1  synchronous buffer clear, active-high
min_digit  out  4  buffer minutes digit, BCD; also counter data
sec_tens_digit  out  4  buffer seconds-tens digit, BCD; also counter data
sec_ones_digit  out  4  buffer seconds-ones digit, BCD; also counter data
loadn  out  1  active-low one-cycle load strobe to all three counters
loaded  out  1  one-cycle pulse the cycle after loadn; controller may enable counting
error  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (clear=1 at posedge): all digits 0, loadn=1, loaded=0, error=0, FSM=ENTRY, keypad_q=0, held=0. Overrides every other input that cycle.
- Key capture: keypad is registered into keypad_q each cycle.
  - held = |keypad_q from the previous cycle.
  - A press event exists when keypad_q is exactly one-hot and held=0.
  - Multi-bit or all-zero keypad_q produces no event. No new event fires until keypad_q returns to all-zero.
  - A key is encoded to BCD i.
  - Latency: keypad asserted before edge k shows on the digit outputs after edge k+1.
  - Key tracking (keypad_q, held) runs in every state, so a key held through LOAD or ARM never fires later.
- Shift on a press event in ENTRY with enable=1: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key. The old min is discarded. No range check during entry. Example: 1,2,3 gives 1:23; then 4 gives 2:34.
- FSM states are ENTRY, LOAD, ARM, ERR.
- ENTRY, decided in this priority order:
  1. cancel=1: clear the buffer and stay in ENTRY.
  2. start=1, enable=1, buffer nonzero, sec_tens<=SEC_TENS_MAX: go to LOAD.
  3. start=1, enable=1, sec_tens>SEC_TENS_MAX: go to ERR.
  4. start with an all-zero buffer, or with enable=0: ignored.
  - When start is taken, a same-cycle key event is discarded. The buffer is validated as it stood before the key.
- LOAD (1 cycle): loadn=0 and the digit outputs hold the buffer unchanged. Keys, start and cancel are ignored. Next state is ARM.
- ARM (1 cycle): loaded=1 and the buffer clears to 0. Next state is ENTRY.
- ERR (1 cycle): error=1 and the buffer clears to 0. Next state is ENTRY.
- loadn, loaded and error are registered outputs decoded from state. They are never asserted together.
- enable falling mid-entry freezes the buffer; entry resumes when enable rises again.
- enable falling in LOAD/ARM does not abort the sequence.
- The downstream counter gives en priority over loadn, so the controller must hold counter en low until loaded.

Decomposition:
- Shared timer package holds the FSM state encoding (2-bit: ENTRY, LOAD, ARM, ERR), the BCD_ZERO constant and the SEC_TENS_MAX default.
- One natural sub-module: key_press_detect. It contains the keypad register, held flag, one-hot check and BCD encoder, and outputs press (1 bit) plus key_bcd (4 bits).
- FSM and buffer stay in the top module.

Test Plan:
- clear mid-entry with buffer 2:34 -> next cycle all digits 0, loadn=1, loaded=error=0.
- Press 1, 2, 3, each held 5 cycles with 3-cycle gaps -> digits 1:23. Exactly one shift per press; each shift is seen 2 cycles after the key rises.
- Buffer 1:23, start=1 -> loadn=0 for 1 cycle with outputs 1,2,3. Next cycle loaded=1 and digits become 0:00. Back in ENTRY after that.
- Press 7, 5 (buffer 0:75), start -> error=1 for 1 cycle, loadn never low, buffer 0:00.
- keypad=0b0000000101 (two keys) -> no shift. Release, then press 9 -> sec_ones=9.
- Same-cycle start and key 4 with buffer 0:12 -> loads 0:12 and key 4 is lost. Same-cycle cancel and start -> buffer 0:00 and no loadn.

Source files
------------

// File: rtl/time_entry_register_pkg.sv
// time_entry_register_pkg: shared timer types and defaults
package time_entry_register_pkg;
   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARM   = 2'd2,
      ST_ERR   = 2'd3
   } state_e;
   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam int unsigned SEC_TENS_MAX_DEF = 5;
   localparam int unsigned KEYS_DEF = 10;
endpackage

// File: rtl/time_entry_register_key_press_detect.sv
// key_press_detect: registers keypad and emits one press per clean one-hot key
module key_press_detect
   import time_entry_register_pkg::*;
#(
   parameter int unsigned KEYS = KEYS_DEF
) (
   input  logic            clock_i,
   input  logic            clear_i,
   input  logic [KEYS-1:0] keypad_i,
   output logic            press_o,
   output logic [3:0]      key_bcd_o
);
   logic [KEYS-1:0] keypad_q, keypad_d;
   logic            held_q, held_d;
   assign keypad_d = clear_i ? '0 : keypad_i;
   assign held_d   = clear_i ? 1'b0 : |keypad_q;
   always_ff @(posedge clock_i) begin
      keypad_q <= keypad_d;
      held_q   <= held_d;
   end
   always_comb begin
      key_bcd_o = BCD_ZERO;
      for (int i = 0; i < KEYS; i++) key_bcd_o = keypad_q[i] ? 4'(i) : key_bcd_o;
   end
   // held blocks a new event until the keypad has been all-zero for a cycle
   assign press_o = $onehot(keypad_q) && !held_q;
endmodule

// File: rtl/time_entry_register.sv
// time_entry_register: keypad M:SS entry buffer with validated one-cycle counter load
module time_entry_register
   import time_entry_register_pkg::*;
#(
   parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF,
   parameter int unsigned KEYS         = KEYS_DEF
) (
   input  logic            clock_i,
   input  logic            clear_i,
   input  logic [KEYS-1:0] keypad_i,
   input  logic            enable_i,
   input  logic            start_i,
   input  logic            cancel_i,
   output logic [3:0]      min_digit_o,
   output logic [3:0]      sec_tens_digit_o,
   output logic [3:0]      sec_ones_digit_o,
   output logic            loadn_o,
   output logic            loaded_o,
   output logic            error_o
);
   state_e     state_q, state_d;
   logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
   logic       loadn_q, loadn_d, loaded_q, loaded_d, error_q, error_d;
   logic       press;
   logic [3:0] key_bcd;
   logic       in_entry, nonzero, tens_bad, take_load, take_err, shift, wipe;
   key_press_detect #(.KEYS(KEYS)) u_key_press_detect (
      .clock_i  (clock_i),
      .clear_i  (clear_i),
      .keypad_i (keypad_i),
      .press_o  (press),
      .key_bcd_o(key_bcd)
   );
   assign in_entry  = state_q == ST_ENTRY;
   assign nonzero   = |{min_q, tens_q, ones_q};
   assign tens_bad  = tens_q > 4'(SEC_TENS_MAX);
   assign take_load = in_entry && !cancel_i && start_i && enable_i && nonzero && !tens_bad;
   assign take_err  = in_entry && !cancel_i && start_i && enable_i && tens_bad;
   // a taken start swallows any same-cycle key so the validated buffer is what loads
   assign shift     = in_entry && !cancel_i && !take_load && !take_err && press && enable_i;
   assign wipe      = (in_entry && cancel_i) || take_err || state_q == ST_LOAD;
   always_ff @(posedge clock_i) begin
      state_q  <= clear_i ? ST_ENTRY : state_d;
      min_q    <= clear_i ? BCD_ZERO : min_d;
      tens_q   <= clear_i ? BCD_ZERO : tens_d;
      ones_q   <= clear_i ? BCD_ZERO : ones_d;
      loadn_q  <= clear_i ? 1'b1 : loadn_d;
      loaded_q <= clear_i ? 1'b0 : loaded_d;
      error_q  <= clear_i ? 1'b0 : error_d;
   end
   always_comb begin
      state_d = take_load ? ST_LOAD : take_err ? ST_ERR : state_q == ST_LOAD ? ST_ARM : ST_ENTRY;
      min_d   = wipe ? BCD_ZERO : shift ? tens_q : min_q;
      tens_d  = wipe ? BCD_ZERO : shift ? ones_q : tens_q;
      ones_d  = wipe ? BCD_ZERO : shift ? key_bcd : ones_q;
   end
   always_comb begin
      loadn_d  = state_d != ST_LOAD;
      loaded_d = state_d == ST_ARM;
      error_d  = state_d == ST_ERR;
   end
   assign min_digit_o      = min_q;
   assign sec_tens_digit_o = tens_q;
   assign sec_ones_digit_o = ones_q;
   assign loadn_o          = loadn_q;
   assign loaded_o         = loaded_q;
   assign error_o          = error_q;
endmodule
